// File: rtl/hilo_pkg.sv
// Shared CPU package for the HI/LO accumulator.
// Holds the op_mode encodings and the accumulator FSM state encoding so that
// the datapath, the decoder and any testbench agree on one set of values.
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;

    // IDLE accepts requests; ACC is the single cycle that finishes the high half.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_addsub_half.sv
// One W-bit half of the HILO accumulator adder.
// Ports:
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   sum   : W-bit result
//   cout  : carry out of bit W-1
module hilo_addsub_half #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Zero-extend to W+1 bits so the top bit of the result is the carry.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with a two-cycle multiply-accumulate path.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   op_valid  : request this cycle;  op_ready : request can be accepted
//   op_mode   : NOP / MTHI / MTLO / WRITE / MADD / MSUB (6,7 act as NOP)
//   hi_i, lo_i: write data for MTHI / MTLO / WRITE
//   prod_i    : 2W-bit precomputed product for MADD / MSUB
//   flush     : drop a request in IDLE or abort the accumulate in ACC
//   hilo_o    : {HI, LO}, bypassing write data in the acceptance cycle
//   busy      : accumulate in flight
module hilo_acc
    import hilo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [2:0]     op_mode,
    input  logic [W-1:0]   hi_i,
    input  logic [W-1:0]   lo_i,
    input  logic [2*W-1:0] prod_i,
    input  logic           flush,
    output logic [2*W-1:0] hilo_o,
    output logic           busy
);

    hilo_state_t state, next_state;

    logic [W-1:0]   hi, lo;
    logic [W-1:0]   lo_sum_q;
    logic           carry_q;
    logic [W-1:0]   operand_hi_q;

    logic           accept;
    logic           write_hi, write_lo;
    logic           start_acc, commit_acc;
    logic [2*W-1:0] operand;
    logic [W-1:0]   lo_sum, hi_sum;
    logic           lo_cout;
    logic           hi_cout_unused;

    // MSUB accumulates the two's-complement negation, so a single adder chain
    // serves both directions.
    assign operand = (op_mode == OP_MSUB) ? (-prod_i) : prod_i;

    // Low half is summed in the acceptance cycle and its carry is registered,
    // which keeps the carry chain to W bits per cycle.
    hilo_addsub_half #(.W(W)) u_lo_add (
        .a    (lo),
        .b    (operand[W-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // High half is finished in ACC from the registered operand and carry;
    // its carry out falls off the top since arithmetic wraps modulo 2^(2W).
    hilo_addsub_half #(.W(W)) u_hi_add (
        .a    (hi),
        .b    (operand_hi_q),
        .cin  (carry_q),
        .sum  (hi_sum),
        .cout (hi_cout_unused)
    );

    // Decode the request, choose the next FSM state and which registers load.
    always_comb begin
        next_state = state;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        start_acc  = 1'b0;
        commit_acc = 1'b0;
        accept     = op_valid && op_ready && !flush;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_mode)
                        OP_MTHI:  write_hi = 1'b1;
                        OP_MTLO:  write_lo = 1'b1;
                        OP_WRITE: begin
                            write_hi = 1'b1;
                            write_lo = 1'b1;
                        end
                        OP_MADD, OP_MSUB: begin
                            start_acc  = 1'b1;
                            next_state = ST_ACC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ACC: begin
                next_state = ST_IDLE;
                commit_acc = !flush;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign op_ready = (state == ST_IDLE);
    assign busy     = (state == ST_ACC);

    // Write data is forwarded in its acceptance cycle; accumulate results are not.
    assign hilo_o = {write_hi ? hi_i : hi, write_lo ? lo_i : lo};

    // All architectural and pipeline state lives in this one register block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            hi           <= '0;
            lo           <= '0;
            lo_sum_q     <= '0;
            carry_q      <= 1'b0;
            operand_hi_q <= '0;
        end else begin
            state <= next_state;
            if (write_hi) hi <= hi_i;
            if (write_lo) lo <= lo_i;
            if (start_acc) begin
                lo_sum_q     <= lo_sum;
                carry_q      <= lo_cout;
                operand_hi_q <= operand[2*W-1:W];
            end
            if (commit_acc) begin
                hi <= hi_sum;
                lo <= lo_sum_q;
            end
        end
    end

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc (W=32). Expected HILO values come from a
// plain 64-bit model, are pushed to a scoreboard queue when stimulus is
// driven and popped when the DUT output is sampled on the falling edge.
module tb_hilo_acc;
    import hilo_pkg::*;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [2:0]     op_mode;
    logic [W-1:0]   hi_i;
    logic [W-1:0]   lo_i;
    logic [2*W-1:0] prod_i;
    logic           flush;
    logic [2*W-1:0] hilo_o;
    logic           busy;

    int tests_run;
    int tests_failed;

    logic [63:0] exp_q[$];
    logic [63:0] model;
    logic [63:0] exp_val;

    hilo_acc #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_mode  (op_mode),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .prod_i   (prod_i),
        .flush    (flush),
        .hilo_o   (hilo_o),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] h,
                         input logic [31:0] l, input logic [63:0] p, input logic f);
        op_valid = v;
        op_mode  = m;
        hi_i     = h;
        lo_i     = l;
        prod_i   = p;
        flush    = f;
    endtask

    task automatic drive_idle();
        drive(1'b0, OP_NOP, 32'h0, 32'h0, 64'h0, 1'b0);
    endtask

    // Preload HILO through a WRITE; it lands on the next rising edge.
    task automatic load_value(input logic [63:0] v);
        next_cycle();
        drive(1'b1, OP_WRITE, v[63:32], v[31:0], 64'h0, 1'b0);
        model = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #3;
        tests_run++;
        if (hilo_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hilo: got %h want %h", hilo_o, 64'h0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        tests_run++;
        if (op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b want 1", op_ready);
        end
        next_cycle();
        rst   = 1'b0;
        model = 64'h0;
    endtask

    task automatic test_write();
        next_cycle();
        drive(1'b1, OP_WRITE, 32'h12345678, 32'h9ABCDEF0, 64'h0, 1'b0);
        model = 64'h123456789ABCDEF0;
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL write_bypass: got %h want %h", hilo_o, exp_val);
        end
        next_cycle();
        drive_idle();
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL write_held: got %h want %h", hilo_o, exp_val);
        end
    endtask

    task automatic test_madd_carry();
        load_value(64'h00000000FFFFFFFF);
        next_cycle();
        drive(1'b1, OP_MADD, 32'h0, 32'h0, 64'h1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL madd_accept_ready: got %b want 1", op_ready);
        end
        // Request held during ACC must be ignored and not bypassed.
        next_cycle();
        drive(1'b1, OP_WRITE, 32'hDEADDEAD, 32'hBEEFBEEF, 64'h0, 1'b0);
        exp_q.push_back(model);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL madd_busy: got %b want 1", busy);
        end
        tests_run++;
        if (op_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL madd_ready_low: got %b want 0", op_ready);
        end
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL madd_in_acc: got %h want %h", hilo_o, exp_val);
        end
        next_cycle();
        drive_idle();
        model = model + 64'h1;
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val || exp_val !== 64'h0000000100000000) begin
            tests_failed++;
            $display("[TB] FAIL madd_carry: got %h want %h", hilo_o, 64'h0000000100000000);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL madd_busy_clear: got %b want 0", busy);
        end
    endtask

    task automatic test_msub_wrap();
        load_value(64'h0);
        next_cycle();
        drive(1'b1, OP_MSUB, 32'h0, 32'h0, 64'h1, 1'b0);
        model = model - 64'h1;
        exp_q.push_back(model);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL msub_wrap: got %h want %h", hilo_o, exp_val);
        end
    endtask

    task automatic test_flush_acc();
        load_value(64'h5);
        next_cycle();
        drive(1'b1, OP_MADD, 32'h0, 32'h0, 64'h10, 1'b0);
        next_cycle();
        drive(1'b0, OP_NOP, 32'h0, 32'h0, 64'h0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_acc_busy: got %b want 1", busy);
        end
        next_cycle();
        drive_idle();
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL flush_acc_hilo: got %h want %h", hilo_o, exp_val);
        end
        tests_run++;
        if (op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_acc_ready: got %b want 1", op_ready);
        end
    endtask

    task automatic test_flush_idle();
        next_cycle();
        drive(1'b1, OP_MTLO, 32'h0, 32'hAAAA5555, 64'h0, 1'b1);
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL flush_idle_drop: got %h want %h", hilo_o, exp_val);
        end
        next_cycle();
        drive(1'b1, OP_MTHI, 32'h1, 32'hFFFFFFFF, 64'h0, 1'b0);
        model = {32'h1, model[31:0]};
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL mthi_bypass: got %h want %h", hilo_o, exp_val);
        end
        next_cycle();
        drive_idle();
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL mthi_held: got %h want %h", hilo_o, exp_val);
        end
    endtask

    task automatic test_async_reset();
        load_value(64'h77);
        next_cycle();
        drive(1'b1, OP_MADD, 32'h0, 32'h0, 64'h9, 1'b0);
        next_cycle();
        drive_idle();
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (hilo_o !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_rst_hilo: got %h want %h", hilo_o, 64'h0);
        end
        tests_run++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL async_rst_ctrl: got busy=%b ready=%b want busy=0 ready=1", busy, op_ready);
        end
        #1 rst = 1'b0;
        model = 64'h0;
        next_cycle();
        drive(1'b1, OP_MADD, 32'h0, 32'h0, 64'h3, 1'b0);
        model = model + 64'h3;
        exp_q.push_back(model);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL async_rst_madd: got %h want %h", hilo_o, exp_val);
        end
    endtask

    task automatic test_back_to_back();
        load_value(64'h10);
        next_cycle();
        drive(1'b1, OP_MADD, 32'h0, 32'h0, 64'h5, 1'b0);
        model = model + 64'h5;
        next_cycle();
        drive_idle();
        next_cycle();
        drive(1'b1, OP_MSUB, 32'h0, 32'h0, 64'h3, 1'b0);
        exp_q.push_back(model);
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val || op_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got %h ready=%b want %h ready=1", hilo_o, op_ready, exp_val);
        end
        model = model - 64'h3;
        exp_q.push_back(model);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        exp_val = exp_q.pop_front();
        tests_run++;
        if (hilo_o !== exp_val) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got %h want %h", hilo_o, exp_val);
        end
    endtask

    task automatic test_random();
        logic [2:0]  m;
        logic [31:0] h, l;
        logic [63:0] p;
        logic        f;
        logic [63:0] bypass;
        for (int i = 0; i < 24; i++) begin
            m = 3'($urandom_range(0, 7));
            h = $urandom;
            l = $urandom;
            p = {$urandom, $urandom};
            f = ($urandom_range(0, 3) == 0);
            next_cycle();
            drive(1'b1, m, h, l, p, f);
            bypass = model;
            if (!f) begin
                if (m == OP_MTHI)  bypass = {h, model[31:0]};
                if (m == OP_MTLO)  bypass = {model[63:32], l};
                if (m == OP_WRITE) bypass = {h, l};
            end
            exp_q.push_back(bypass);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            tests_run++;
            if (hilo_o !== exp_val) begin
                tests_failed++;
                $display("[TB] FAIL rand_accept[%0d] mode=%0d flush=%b: got %h want %h",
                         i, m, f, hilo_o, exp_val);
            end
            model = bypass;
            if (!f && (m == OP_MADD || m == OP_MSUB)) begin
                next_cycle();
                drive_idle();
                @(negedge clk);
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_busy[%0d]: got %b want 1", i, busy);
                end
                model = (m == OP_MADD) ? model + p : model - p;
                exp_q.push_back(model);
                next_cycle();
                @(negedge clk);
                exp_val = exp_q.pop_front();
                tests_run++;
                if (hilo_o !== exp_val) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_acc[%0d] mode=%0d: got %h want %h", i, m, hilo_o, exp_val);
                end
            end
        end
        next_cycle();
        drive_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_write();
        test_madd_carry();
        test_msub_wrap();
        test_flush_acc();
        test_flush_idle();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 Parameter W, default 32, width of each of HI and LO in bits; the HILO pair is 2W bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op_valid  input  1  operation request this cycle.
REQ-005 op_ready  output  1  block accepts a request this cycle.
REQ-006 op_mode  input  3  operation: 0 NOP, 1 MTHI, 2 MTLO, 3 WRITE (both halves), 4 MADD, 5 MSUB; 6/7 treated as NOP.
REQ-007 hi_i  input  W  HI write data for MTHI/WRITE.
REQ-008 lo_i  input  W  LO write data for MTLO/WRITE.
REQ-009 prod_i  input  2W  precomputed product for MADD/MSUB.
REQ-010 flush  input  1  abort any in-flight accumulate (exception/pipeline flush).
REQ-011 hilo_o  output  2W  current HILO value {HI, LO}, with bypass per REQ-017.
REQ-012 busy  output  1  accumulate in flight.

Function
REQ-013 A request is accepted when op_valid && op_ready && !flush; op_ready = 1 in IDLE, 0 in ACC.
REQ-014 MTHI/MTLO/WRITE accepted: the addressed half (or both) is written at the next edge; the other half holds.
REQ-015 MADD/MSUB accepted: the FSM goes IDLE->ACC, capturing prod_i (MSUB: two's-complement negation of prod_i) and the low-half sum {carry, LO+operand[W-1:0]} into internal registers.
REQ-016 In ACC (exactly one cycle): HI <= HI + operand[2W-1:W] + carry, LO <= registered low sum; the FSM returns to IDLE. Accumulate latency is 2 edges from acceptance; throughput is 1 accumulate per 2 cycles.
REQ-017 Bypass: in the acceptance cycle of MTHI/MTLO/WRITE, hilo_o presents the value to be written (unwritten half from the register); otherwise hilo_o = registered {HI, LO}. No bypass of accumulate results; the result is visible the cycle after ACC.
REQ-018 Arithmetic is modulo 2^(2W); no overflow flag; signed and unsigned results are identical because prod_i is already extended.
REQ-019 flush in ACC: no HI/LO update; the FSM returns to IDLE; HILO retains its pre-MADD value.
REQ-020 flush concurrent with op_valid in IDLE: the request is dropped with no state change.
REQ-021 NOP and modes 6/7 when accepted: no state change.
REQ-022 busy = 1 exactly in ACC.

Reset
REQ-023 rst asserted: HI = 0, LO = 0, carry/operand registers = 0, FSM = IDLE, immediately and independent of clk.
REQ-024 Outputs under reset: hilo_o = 0, busy = 0, op_ready = 1.
REQ-025 rst asserted mid-accumulate discards the operation; the first edge after release sees IDLE.

Structure
REQ-026 op_mode encodings and FSM state encoding belong in the shared CPU package (hilo_pkg constants).
REQ-027 One sub-module, hilo_addsub_half (W-bit adder with carry-in/out), is instantiated twice for the low and high halves.
REQ-028 No other submodules; a single always block holds the state registers.

Verification (W=32)
REQ-029 Reset, then WRITE hi_i=0x12345678, lo_i=0x9ABCDEF0 -> hilo_o=0x123456789ABCDEF0 in the same cycle (bypass) and thereafter.
REQ-030 From 0x00000000FFFFFFFF, MADD prod_i=0x1 -> busy high one cycle, op_ready low; two edges later hilo_o=0x0000000100000000 (carry crosses halves).
REQ-031 From 0x0, MSUB prod_i=0x1 -> hilo_o=0xFFFFFFFFFFFFFFFF after two edges (wrap-around).
REQ-032 From 0x5, MADD prod_i=0x10, flush asserted in ACC cycle -> hilo_o stays 0x5, op_ready high next cycle.
REQ-033 MTLO lo_i=0xAAAA5555 with flush same cycle -> no change; then MTHI hi_i=0x1 alone -> HI=0x1, LO unchanged.
REQ-034 rst pulsed asynchronously between edges during ACC -> hilo_o=0, busy=0 immediately; next MADD prod_i=0x3 yields 0x3.
